// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command receiver: mode helpers, FSM states
// and the default-width queue entry layout.
package spi_pkg;

    localparam int SPI_MODE_0 = 0;
    localparam int SPI_MODE_1 = 1;
    localparam int SPI_MODE_2 = 2;
    localparam int SPI_MODE_3 = 3;

    localparam int CMD_W_DEF  = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } rx_state_t;

    typedef struct packed {
        logic                  first;
        logic [CMD_W_DEF-1:0]  cmd;
        logic [DATA_W_DEF-1:0] data;
    } rx_entry_t;

    function automatic logic mode_cpol(input int mode);
        logic [1:0] m;
        m = 2'(mode);
        return m[1];
    endfunction

    // Leading edge (CPHA=0) or trailing edge (CPHA=1) relative to the idle level.
    function automatic logic mode_sample_rise(input int mode);
        logic [1:0] m;
        m = 2'(mode);
        return m[1] == m[0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a pop and a push in the same cycle are both
// honoured even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + (AW+1)'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/spi_cmd_rx.sv
// Oversampling SPI slave receiver: frames each chip-select window into a
// command followed by a burst of data words and queues them for the consumer.
module spi_cmd_rx
    import spi_pkg::*;
#(
    parameter int CMD_WIDTH   = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  csb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CMD_WIDTH-1:0]  out_cmd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_first,
    output logic                  frame_err,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic                  busy
);
    localparam logic CPOL        = mode_cpol(SPI_MODE);
    localparam logic SAMPLE_RISE = mode_sample_rise(SPI_MODE);
    localparam int   SH_W        = (DATA_WIDTH > CMD_WIDTH) ? DATA_WIDTH : CMD_WIDTH;
    localparam int   CNT_W       = $clog2(SH_W + 1);
    localparam int   PRIME_W     = $clog2(SYNC_STAGES + 1);

    typedef struct packed {
        logic                  first;
        logic [CMD_WIDTH-1:0]  cmd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, csb_sync_reg;
    logic                   sclk_hist_reg, csb_hist_reg;
    logic [PRIME_W-1:0]     prime_cnt_reg;
    logic                   armed_reg;
    logic                   sclk_s, mosi_s, csb_s;
    logic                   prime_done, sample_edge, csb_fall, csb_rise;

    assign sclk_s     = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_reg[SYNC_STAGES-1];
    assign csb_s      = csb_sync_reg[SYNC_STAGES-1];
    assign prime_done = (prime_cnt_reg == PRIME_W'(SYNC_STAGES));
    assign csb_fall   = csb_hist_reg & ~csb_s;
    assign csb_rise   = ~csb_hist_reg & csb_s;
    assign sample_edge = ~csb_s & (SAMPLE_RISE ? (sclk_s & ~sclk_hist_reg)
                                               : (~sclk_s & sclk_hist_reg));

    // Arming waits until the chain holds real samples and csb has been seen
    // high, so a frame already running at reset release is skipped entirely.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= {SYNC_STAGES{CPOL}};
            mosi_sync_reg <= '0;
            csb_sync_reg  <= '1;
            sclk_hist_reg <= CPOL;
            csb_hist_reg  <= 1'b1;
            prime_cnt_reg <= '0;
            armed_reg     <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
            csb_sync_reg  <= {csb_sync_reg[SYNC_STAGES-2:0], csb};
            sclk_hist_reg <= sclk_s;
            csb_hist_reg  <= csb_s;
            if (!prime_done)        prime_cnt_reg <= prime_cnt_reg + PRIME_W'(1);
            if (prime_done && csb_s) armed_reg    <= 1'b1;
        end
    end

    rx_state_t             state_reg, state_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [SH_W-2:0]       shift_reg, shift_next;
    logic [CMD_WIDTH-1:0]  cmd_reg, cmd_next;
    logic                  first_reg, first_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  overflow_reg;
    logic [SH_W-1:0]       shift_in;
    logic                  push, pop, fifo_full, fifo_empty;
    entry_t                push_entry, head;
    logic [$bits(entry_t)-1:0]     fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    assign shift_in   = {shift_reg, mosi_s};
    assign push_entry = '{first: first_reg, cmd: cmd_reg, data: DATA_WIDTH'(shift_in)};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            cmd_reg       <= '0;
            first_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            cmd_reg       <= cmd_next;
            first_reg     <= first_next;
            frame_err_reg <= frame_err_next;
            if (push && fifo_full && !pop) overflow_reg <= 1'b1;
            else if (overflow_clr)         overflow_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        cmd_next       = cmd_reg;
        first_next     = first_reg;
        frame_err_next = 1'b0;
        push           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (csb_fall && armed_reg) begin
                    state_next   = ST_CMD;
                    bit_cnt_next = '0;
                end
            end
            ST_CMD: begin
                if (csb_rise) begin
                    state_next     = ST_IDLE;
                    frame_err_next = (bit_cnt_reg != '0);
                end else if (sample_edge) begin
                    shift_next = shift_in[SH_W-2:0];
                    if (bit_cnt_reg == CNT_W'(CMD_WIDTH - 1)) begin
                        cmd_next     = CMD_WIDTH'(shift_in);
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                        first_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (csb_rise) begin
                    state_next     = ST_IDLE;
                    frame_err_next = (bit_cnt_reg != '0);
                end else if (sample_edge) begin
                    shift_next = shift_in[SH_W-2:0];
                    if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                        push         = 1'b1;
                        bit_cnt_next = '0;
                        first_next   = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head      = entry_t'(fifo_rdata);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_cmd   = fifo_empty ? '0 : head.cmd;
    assign out_data  = fifo_empty ? '0 : head.data;
    assign out_first = fifo_empty ? 1'b0 : head.first;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;
    assign busy      = ~csb_s;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Drives three receivers (modes 0, 3, 1) with the same bit stream and checks
// each against a frame-level model of the command/burst queue.
module tb_spi_cmd_rx;
    localparam int S = 2;

    logic sys_clk = 1'b0;
    logic rst_n, mosi, csb, out_ready, overflow_clr;
    logic sclk_m0, sclk_m3, sclk_m1;
    logic        out_valid_w [3];
    logic [7:0]  out_cmd_w   [3];
    logic [15:0] out_data_w  [3];
    logic        out_first_w [3];
    logic        frame_err_w [3];
    logic        overflow_w  [3];
    logic        busy_w      [3];

    always #5 sys_clk = ~sys_clk;

    spi_cmd_rx #(.SPI_MODE(0), .SYNC_STAGES(S)) dut_m0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .sclk(sclk_m0), .mosi(mosi), .csb(csb),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_cmd(out_cmd_w[0]),
        .out_data(out_data_w[0]), .out_first(out_first_w[0]), .frame_err(frame_err_w[0]),
        .overflow(overflow_w[0]), .overflow_clr(overflow_clr), .busy(busy_w[0]));
    spi_cmd_rx #(.SPI_MODE(3), .SYNC_STAGES(S)) dut_m3 (
        .sys_clk(sys_clk), .rst_n(rst_n), .sclk(sclk_m3), .mosi(mosi), .csb(csb),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_cmd(out_cmd_w[1]),
        .out_data(out_data_w[1]), .out_first(out_first_w[1]), .frame_err(frame_err_w[1]),
        .overflow(overflow_w[1]), .overflow_clr(overflow_clr), .busy(busy_w[1]));
    spi_cmd_rx #(.SPI_MODE(1), .SYNC_STAGES(S)) dut_m1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .sclk(sclk_m1), .mosi(mosi), .csb(csb),
        .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_cmd(out_cmd_w[2]),
        .out_data(out_data_w[2]), .out_first(out_first_w[2]), .frame_err(frame_err_w[2]),
        .overflow(overflow_w[2]), .overflow_clr(overflow_clr), .busy(busy_w[2]));

    typedef struct { int due; logic [7:0] cmd; logic [15:0] data; logic first; } pend_t;
    typedef struct { logic [7:0] cmd; logic [15:0] data; logic first; } ent_t;

    pend_t pend[$];
    ent_t  mq[$];
    int    err_due[$];
    logic  m_ovf = 1'b0;
    int    n_cmp = 0, n_bad = 0, cyc = 0, ferr_seen = 0;
    int    ready_mode = 0;
    bit    clr_req = 0;

    bit         f_track;
    int         f_n;
    logic [31:0] f_acc;
    logic [7:0] f_cmd;
    logic       f_first;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Every-cycle comparison; also drives the consumer side and advances the model.
    initial begin : compare
        bit   exp_err, rdy, clr, dropped;
        int   tmp;
        ent_t e;
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    chk("rst_valid", out_valid_w[k], 0);
                    chk("rst_cmd", out_cmd_w[k], 0);
                    chk("rst_data", out_data_w[k], 0);
                    chk("rst_ovf", overflow_w[k], 0);
                    chk("rst_busy", busy_w[k], 0);
                end
                mq.delete(); pend.delete(); err_due.delete(); m_ovf = 1'b0;
                out_ready = 1'b0; overflow_clr = 1'b0;
                continue;
            end
            exp_err = 0;
            while (err_due.size() > 0 && err_due[0] <= cyc) begin
                if (err_due[0] == cyc) exp_err = 1;
                tmp = err_due.pop_front();
            end
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("valid%0d", k), out_valid_w[k], mq.size() > 0);
                if (mq.size() > 0) begin
                    chk($sformatf("cmd%0d", k), out_cmd_w[k], mq[0].cmd);
                    chk($sformatf("data%0d", k), out_data_w[k], mq[0].data);
                    chk($sformatf("first%0d", k), out_first_w[k], mq[0].first);
                end
                chk($sformatf("frame_err%0d", k), frame_err_w[k], exp_err);
                chk($sformatf("overflow%0d", k), overflow_w[k], m_ovf);
            end
            if (frame_err_w[0]) ferr_seen++;
            rdy = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
            clr = clr_req; clr_req = 0;
            out_ready = rdy; overflow_clr = clr;
            if (rdy && mq.size() > 0) e = mq.pop_front();
            dropped = 0;
            while (pend.size() > 0 && pend[0].due == cyc + 1) begin
                if (mq.size() < 4) begin
                    e.cmd = pend[0].cmd; e.data = pend[0].data; e.first = pend[0].first;
                    mq.push_back(e);
                end else dropped = 1;
                pend.delete(0);
            end
            m_ovf = dropped ? 1'b1 : (clr ? 1'b0 : m_ovf);
        end
    end

    task automatic tick();
        @(negedge sys_clk); #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic frame_start(input bit track);
        tick();
        csb = 1'b0;
        f_track = track; f_n = 0; f_acc = '0; f_first = 1'b1;
        wait_cyc(3);
    endtask

    task automatic send_bit(input logic b);
        int    h;
        pend_t p;
        h = $urandom_range(2, 5);
        mosi = b; sclk_m0 = 1'b0; sclk_m3 = 1'b0; sclk_m1 = 1'b1;
        wait_cyc(h);
        sclk_m0 = 1'b1; sclk_m3 = 1'b1; sclk_m1 = 1'b0;
        f_acc = {f_acc[30:0], b};
        f_n++;
        if (f_track && !csb) begin
            if (f_n == 8) begin
                f_cmd = f_acc[7:0]; f_acc = '0;
            end else if (f_n > 8 && (f_n - 8) % 16 == 0) begin
                p.due = cyc + S + 1; p.cmd = f_cmd; p.data = f_acc[15:0]; p.first = f_first;
                pend.push_back(p);
                f_first = 1'b0; f_acc = '0;
            end
        end
        wait_cyc(h);
    endtask

    task automatic frame_end();
        sclk_m0 = 1'b0; sclk_m3 = 1'b1; sclk_m1 = 1'b0;
        wait_cyc(3);
        csb = 1'b1;
        if (f_track && ((f_n > 0 && f_n < 8) || (f_n > 8 && (f_n - 8) % 16 != 0)))
            err_due.push_back(cyc + S + 1);
        wait_cyc(4);
    endtask

    task automatic send_frame(input logic [63:0] bits, input int nbits);
        frame_start(1);
        for (int i = 0; i < nbits; i++) send_bit(bits[nbits-1-i]);
        frame_end();
    endtask

    task automatic chk_head(input string nm, input int k, input logic [7:0] c,
                            input logic [15:0] d, input logic f);
        chk({nm, "_valid"}, out_valid_w[k], 1);
        chk({nm, "_cmd"}, out_cmd_w[k], c);
        chk({nm, "_data"}, out_data_w[k], d);
        chk({nm, "_first"}, out_first_w[k], f);
    endtask

    initial begin
        logic [63:0] rbits;
        int          nb, fe0;
        rst_n = 1'b0; csb = 1'b1; mosi = 1'b0;
        sclk_m0 = 1'b0; sclk_m3 = 1'b1; sclk_m1 = 1'b0;
        out_ready = 1'b0; overflow_clr = 1'b0;
        wait_cyc(4);
        for (int k = 0; k < 3; k++) begin
            chk("reset_first", out_first_w[k], 0);
            chk("reset_frame_err", frame_err_w[k], 0);
        end
        rst_n = 1'b1;
        wait_cyc(6);

        // single frame
        frame_start(1);
        for (int k = 0; k < 3; k++) chk("busy_in_frame", busy_w[k], 1);
        rbits = 64'h674089;
        for (int i = 0; i < 24; i++) send_bit(rbits[23-i]);
        frame_end();
        wait_cyc(2);
        chk_head("single", 0, 8'h67, 16'h4089, 1);
        chk("single_no_ferr", ferr_seen, 0);
        chk("busy_idle", busy_w[0], 0);
        ready_mode = 1; wait_cyc(4); ready_mode = 0;

        // burst: pop exactly one entry between the two head checks
        send_frame(64'h67_4089_1234, 40);
        wait_cyc(2);
        chk_head("burst0", 0, 8'h67, 16'h4089, 1);
        ready_mode = 1; tick(); ready_mode = 0; tick();
        chk_head("burst1", 0, 8'h67, 16'h1234, 0);
        ready_mode = 1; wait_cyc(4); ready_mode = 0;

        // truncated frame after 13 bits
        fe0 = ferr_seen;
        send_frame(64'h1ABC, 13);
        wait_cyc(2);
        chk("partial_ferr_pulses", ferr_seen - fe0, 1);
        chk("partial_empty", out_valid_w[0], 0);
        send_frame(64'h12_3456, 24);
        wait_cyc(2);
        chk_head("after_err", 0, 8'h12, 16'h3456, 1);
        ready_mode = 1; wait_cyc(4); ready_mode = 0;

        // overflow with stalled consumer
        for (int i = 0; i < 5; i++) send_frame({40'h0, 8'(i), 16'hA000 + 16'(i)}, 24);
        wait_cyc(2);
        chk("ovf_set", overflow_w[0], 1);
        chk_head("ovf_head", 0, 8'h00, 16'hA000, 1);
        clr_req = 1; wait_cyc(3);
        chk("ovf_cleared", overflow_w[0], 0);
        ready_mode = 1; wait_cyc(8); ready_mode = 0;

        // same frame decoded by every mode
        send_frame(64'hA5_BEEF, 24);
        wait_cyc(2);
        for (int k = 0; k < 3; k++) chk_head($sformatf("mode_dut%0d", k), k, 8'hA5, 16'hBEEF, 1);
        ready_mode = 1; wait_cyc(4); ready_mode = 0;

        // sclk activity with csb high is ignored
        f_track = 0;
        for (int i = 0; i < 16; i++) send_bit(1'b1);
        sclk_m0 = 1'b0; sclk_m3 = 1'b1; sclk_m1 = 1'b0;
        wait_cyc(6);
        chk("csb_high_ignored", out_valid_w[0], 0);

        // reset mid-frame; the remainder of that frame must be ignored
        frame_start(1);
        rbits = 64'hFFFFFF;
        for (int i = 0; i < 10; i++) send_bit(rbits[23-i]);
        tick(); rst_n = 1'b0; wait_cyc(3);
        chk("midrst_valid", out_valid_w[0], 0);
        chk("midrst_busy", busy_w[0], 0);
        rst_n = 1'b1; f_track = 0;
        for (int i = 10; i < 24; i++) send_bit(rbits[23-i]);
        frame_end();
        send_frame(64'h01_0002, 24);
        wait_cyc(2);
        chk_head("post_reset", 0, 8'h01, 16'h0002, 1);
        ready_mode = 1; tick(); ready_mode = 0; tick();
        chk("post_reset_only", out_valid_w[0], 0);

        // randomized frames, consumer stalls and overflow clears
        ready_mode = 2;
        for (int f = 0; f < 25; f++) begin
            rbits = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: nb = 24;
                1: nb = 40;
                2: nb = 56;
                3: nb = 8;
                default: nb = $urandom_range(0, 60);
            endcase
            if ($urandom_range(0, 3) == 0) clr_req = 1;
            send_frame(rbits, nb);
        end
        ready_mode = 1;
        wait_cyc(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
